// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder - latency-programmable byte/half/word data-memory responder
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int N_BITS      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [N_BITS-1:0] req_addr,
   input  logic [N_BITS-1:0] req_wdata,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [N_BITS-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int         C_AW     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [N_BITS-1:0] addr_q;
   logic [N_BITS-1:0] wdata_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [N_BITS-1:0] rdata_q;
   logic              err_q;

   logic [N_BITS-1:0] mem_q [DEPTH_WORDS];

   logic [C_AW-1:0]   idx;
   logic [1:0]        lane;
   logic [4:0]        byte_ofs;
   logic [4:0]        half_ofs;
   logic [N_BITS-1:0] word_rd;
   logic [7:0]        byte_rd;
   logic [15:0]       half_rd;
   logic              err_d;
   logic              commit;
   logic [N_BITS-1:0] mem_wr_d;
   logic [N_BITS-1:0] rdata_d;

   assign idx      = addr_q[C_AW+1:2];
   assign lane     = addr_q[1:0];
   assign byte_ofs = {lane, 3'b000};
   assign half_ofs = {lane[1], 4'b0000};
   assign word_rd  = mem_q[idx];
   assign byte_rd  = word_rd[byte_ofs +: 8];
   assign half_rd  = word_rd[half_ofs +: 16];
   assign commit   = (state_q == ST_BUSY) && (cnt_q == 4'd0);

   assign err_d = (size_q == 2'b11)
                | ((size_q == 2'b01) && addr_q[0])
                | ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                | (|addr_q[N_BITS-1:C_AW+2]);

   // Store merge keeps unselected lanes; load path extends the selected field.
   always_comb begin
      mem_wr_d = word_rd;
      rdata_d  = '0;
      case (size_q)
         2'b00: begin
            mem_wr_d[byte_ofs +: 8] = wdata_q[7:0];
            rdata_d = {{(N_BITS-8){~uns_q & byte_rd[7]}}, byte_rd};
         end
         2'b01: begin
            mem_wr_d[half_ofs +: 16] = wdata_q[15:0];
            rdata_d = {{(N_BITS-16){~uns_q & half_rd[15]}}, half_rd};
         end
         default: begin
            mem_wr_d = wdata_q;
            rdata_d  = word_rd;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit && we_q && !err_d) begin
         mem_q[idx] <= mem_wr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  cnt_q   <= C_LAT_M1;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt_q == 4'd0) begin
                  rdata_q <= (err_d || we_q) ? '0 : rdata_d;
                  err_q   <= err_d;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
`default_nettype wire
